// File: rtl/lcd_cmd_sched.sv
// LCD write scheduler: hands off to an external power-up sequencer, then plays a 4-byte config ROM and paces user writes.
// Latency: E rises SETUP_CYCLES+1 cycles after ack; ready stays low (no ack) until setup, pulse and wait have elapsed.
module lcd_cmd_sched #(
    parameter int SETUP_CYCLES = 2,
    parameter int E_CYCLES     = 12,
    parameter int WAIT_CMD     = 2000,
    parameter int WAIT_CLR     = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       init_go,
    input  logic       init_done,
    input  logic [7:0] init_db,
    input  logic       init_e,
    input  logic       req,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       ack,
    output logic       ready,
    output logic [7:0] lcd_db,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw
);
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        INIT_START = 4'd1,
        INIT_WAIT  = 4'd2,
        CFG_SETUP  = 4'd3,
        CFG_PULSE  = 4'd4,
        CFG_WAIT   = 4'd5,
        READY      = 4'd6,
        WR_SETUP   = 4'd7,
        WR_PULSE   = 4'd8,
        WR_WAIT    = 4'd9
    } state_t;

    localparam logic [19:0] SETUP_LAST = 20'(SETUP_CYCLES - 1);
    localparam logic [19:0] E_LAST     = 20'(E_CYCLES - 1);
    localparam logic [19:0] CMD_LAST   = 20'(WAIT_CMD - 1);
    localparam logic [19:0] CLR_LAST   = 20'(WAIT_CLR - 1);

    state_t      state;
    logic [19:0] cnt;
    logic [1:0]  cfg_idx;
    logic [7:0]  byte_q;
    logic        rs_q;
    logic        is_clr;
    logic        cnt_done;

    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long execution wait.
    always_comb begin
        is_clr   = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);
        cnt_done = 1'b0;
        case (state)
            CFG_SETUP, WR_SETUP: cnt_done = (cnt == SETUP_LAST);
            CFG_PULSE, WR_PULSE: cnt_done = (cnt == E_LAST);
            CFG_WAIT, WR_WAIT:   cnt_done = (cnt == (is_clr ? CLR_LAST : CMD_LAST));
            default:             cnt_done = 1'b0;
        endcase
    end

    // Every exit from a timed state clears cnt, so each timed state is entered at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            cfg_idx <= '0;
            byte_q  <= '0;
            rs_q    <= 1'b0;
        end else begin
            case (state)
                IDLE:       if (start) state <= INIT_START;
                INIT_START: state <= INIT_WAIT;
                INIT_WAIT: begin
                    if (init_done) begin
                        state   <= CFG_SETUP;
                        cnt     <= '0;
                        cfg_idx <= 2'd0;
                        byte_q  <= cfg_byte(2'd0);
                        rs_q    <= 1'b0;
                    end
                end
                CFG_SETUP: begin
                    if (cnt_done) begin cnt <= '0; state <= CFG_PULSE; end
                    else cnt <= cnt + 20'd1;
                end
                CFG_PULSE: begin
                    if (cnt_done) begin cnt <= '0; state <= CFG_WAIT; end
                    else cnt <= cnt + 20'd1;
                end
                CFG_WAIT: begin
                    if (cnt_done) begin
                        cnt <= '0;
                        if (cfg_idx == 2'd3) begin
                            state <= READY;
                        end else begin
                            cfg_idx <= cfg_idx + 2'd1;
                            byte_q  <= cfg_byte(cfg_idx + 2'd1);
                            state   <= CFG_SETUP;
                        end
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                READY: begin
                    if (req) begin
                        byte_q <= req_data;
                        rs_q   <= req_rs;
                        cnt    <= '0;
                        state  <= WR_SETUP;
                    end
                end
                WR_SETUP: begin
                    if (cnt_done) begin cnt <= '0; state <= WR_PULSE; end
                    else cnt <= cnt + 20'd1;
                end
                WR_PULSE: begin
                    if (cnt_done) begin cnt <= '0; state <= WR_WAIT; end
                    else cnt <= cnt + 20'd1;
                end
                WR_WAIT: begin
                    if (cnt_done) begin cnt <= '0; state <= READY; end
                    else cnt <= cnt + 20'd1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // ack and the init pass-through must respond within the same cycle, so they are decoded combinationally.
    always_comb begin
        init_go = (state == INIT_START);
        ready   = (state == READY);
        ack     = (state == READY) && req;
        lcd_rw  = 1'b0;
        lcd_e   = 1'b0;
        lcd_db  = 8'h00;
        lcd_rs  = 1'b0;
        case (state)
            INIT_WAIT: begin
                lcd_db = init_db;
                lcd_e  = init_e;
            end
            CFG_SETUP, CFG_WAIT, WR_SETUP, WR_WAIT: begin
                lcd_db = byte_q;
                lcd_rs = rs_q;
            end
            CFG_PULSE, WR_PULSE: begin
                lcd_db = byte_q;
                lcd_rs = rs_q;
                lcd_e  = 1'b1;
            end
            default: begin
                lcd_db = 8'h00;
            end
        endcase
    end
endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Bench for lcd_cmd_sched: per-cycle vector table, hand sequences and random writes checked against an expected bus timeline.
module tb_lcd_cmd_sched;
    localparam int S    = 2;
    localparam int E    = 12;
    localparam int NCMD = 40;
    localparam int NCLR = 150;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       init_done = 1'b0;
    logic       init_e = 1'b0;
    logic [7:0] init_db = 8'h00;
    logic       req = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       init_go, ack, ready, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_db;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_cmd_sched #(
        .SETUP_CYCLES(S), .E_CYCLES(E), .WAIT_CMD(NCMD), .WAIT_CLR(NCLR)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .init_go(init_go),
        .init_done(init_done), .init_db(init_db), .init_e(init_e),
        .req(req), .req_rs(req_rs), .req_data(req_data),
        .ack(ack), .ready(ready), .lcd_db(lcd_db), .lcd_e(lcd_e),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, st, rq, rq_rs;
        logic [7:0] rq_dat;
        logic       idone, ie;
        logic [7:0] idb;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[14];

    // {init_go, ready, ack, lcd_e, lcd_rs, lcd_rw, lcd_db}
    function automatic logic [13:0] bus_now();
        return {init_go, ready, ack, lcd_e, lcd_rs, lcd_rw, lcd_db};
    endfunction

    function automatic vec_t mkv(input logic rst, input logic st, input logic rq, input logic rq_rs,
                                 input logic [7:0] rq_dat, input logic idone, input logic ie,
                                 input logic [7:0] idb, input logic [13:0] exp);
        vec_t v;
        v.rst = rst; v.st = st; v.rq = rq; v.rq_rs = rq_rs; v.rq_dat = rq_dat;
        v.idone = idone; v.ie = ie; v.idb = idb; v.exp = exp;
        return v;
    endfunction

    function automatic int wait_n(input logic rs, input logic [7:0] b);
        return (!rs && b >= 8'd1 && b <= 8'd3) ? NCLR : NCMD;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Walks the expected bus waveform for nb bytes: S setup, E strobe, wait by command class, then one READY cycle.
    task automatic expect_timeline(input string name, input logic [31:0] bytes, input logic rs,
                                   input int nb, input logic hold);
        int errs, t, first_t, n;
        logic [13:0] first_got, first_exp, want;
        logic [7:0] b;
        errs = 0; t = 0; first_t = -1; first_got = '0; first_exp = '0;
        for (int k = 0; k < nb; k++) begin
            b = bytes[8*k +: 8];
            n = S + E + wait_n(rs, b);
            for (int c = 0; c < n; c++) begin
                step(); init_done = 1'b0; if (!hold) req = 1'b0; #1; t++;
                want = {1'b0, 1'b0, 1'b0, (c >= S && c < S + E), rs, 1'b0, b};
                if (bus_now() !== want) begin
                    if (errs == 0) begin first_t = t; first_got = bus_now(); first_exp = want; end
                    errs++;
                end
            end
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL %s timeline: %0d bad cycles, first at t=%0d got %h expected %h",
                     name, errs, first_t, first_got, first_exp);
        end
        step(); init_done = 1'b0; if (!hold) req = 1'b0; #1;
        chk({name, " ready"}, 32'(bus_now()), 32'({1'b0, 1'b1, hold, 11'h000}));
    endtask

    task automatic do_write(input string name, input logic rs, input logic [7:0] d, input logic hold);
        req = 1'b1; req_rs = rs; req_data = d; #1;
        chk({name, " ack"}, 32'({ack, ready}), 32'd3);
        expect_timeline(name, {24'h0, d}, rs, 1, hold);
    endtask

    task automatic bring_up(input string name);
        int errs;
        logic [13:0] want;
        errs = 0;
        step(); start = 1'b1; #1;
        chk({name, " idle"}, 32'(bus_now()), 32'h0);
        step(); start = 1'b0; #1;
        chk({name, " init_go"}, 32'(bus_now()), 32'h2000);
        for (int i = 0; i < 100; i++) begin
            step();
            init_e   = (i == 50) || (i % 7 == 3);
            init_db  = (i == 50) ? 8'h3F : 8'(i * 3);
            req      = (i >= 40 && i < 60);
            req_rs   = 1'b1;
            req_data = 8'h55;
            #1;
            want = {3'b000, init_e, 1'b0, 1'b0, init_db};
            if (bus_now() !== want) errs++;
        end
        chk({name, " passthrough"}, 32'(errs), 32'd0);
        step(); init_done = 1'b1; req = 1'b0; init_e = 1'b0; init_db = 8'h00; #1;
        chk({name, " init_done cycle"}, 32'(bus_now()), 32'h0);
        expect_timeline({name, " cfg"}, 32'h010C0638, 1'b0, 4, 1'b0);
    endtask

    int         dly;
    logic       rr;
    logic [7:0] rd;

    initial begin
        vecs[0]  = mkv(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 14'h0000);
        vecs[1]  = mkv(0, 0, 1, 1, 8'h41, 1, 1, 8'hFF, 14'h0000);
        vecs[2]  = mkv(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 14'h0000);
        vecs[3]  = mkv(0, 1, 1, 0, 8'h00, 0, 1, 8'h55, 14'h2000);
        vecs[4]  = mkv(0, 1, 1, 1, 8'h77, 0, 1, 8'h3F, 14'h043F);
        vecs[5]  = mkv(0, 0, 0, 0, 8'h00, 0, 0, 8'hA5, 14'h00A5);
        vecs[6]  = mkv(1, 1, 1, 0, 8'h00, 1, 1, 8'h12, 14'h0412);
        vecs[7]  = mkv(0, 0, 0, 0, 8'h00, 0, 1, 8'h12, 14'h0000);
        vecs[8]  = mkv(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 14'h0000);
        vecs[9]  = mkv(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 14'h2000);
        vecs[10] = mkv(0, 0, 0, 0, 8'h00, 1, 0, 8'h08, 14'h0008);
        vecs[11] = mkv(0, 0, 1, 0, 8'h00, 0, 1, 8'hFF, 14'h0038);
        vecs[12] = mkv(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 14'h0038);
        vecs[13] = mkv(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 14'h0000);

        step(); step();
        for (int i = 0; i < 14; i++) begin
            step();
            reset = vecs[i].rst; start = vecs[i].st; req = vecs[i].rq; req_rs = vecs[i].rq_rs;
            req_data = vecs[i].rq_dat; init_done = vecs[i].idone; init_e = vecs[i].ie; init_db = vecs[i].idb;
            #1;
            chk($sformatf("vec%0d", i), 32'(bus_now()), 32'(vecs[i].exp));
        end
        reset = 1'b0; start = 1'b0; req = 1'b0; req_rs = 1'b0; req_data = 8'h00;
        init_done = 1'b0; init_e = 1'b0; init_db = 8'h00;

        bring_up("bringup");
        do_write("data41", 1'b1, 8'h41, 1'b0);
        do_write("cmd02",  1'b0, 8'h02, 1'b0);
        do_write("cmd00",  1'b0, 8'h00, 1'b0);
        do_write("cmd03",  1'b0, 8'h03, 1'b0);
        do_write("cmd04",  1'b0, 8'h04, 1'b0);
        do_write("data01", 1'b1, 8'h01, 1'b0);

        do_write("busy1", 1'b1, 8'h33, 1'b1);
        expect_timeline("busy2", 32'h33, 1'b1, 1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            dly = int'($urandom_range(0, 3));
            for (int j = 0; j < dly; j++) begin
                step(); #1;
                chk("ready idle", 32'({ready, ack}), 32'd2);
            end
            rr = 1'($urandom_range(0, 1));
            rd = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            do_write($sformatf("rnd%0d", i), rr, rd, 1'b0);
        end

        // Reset from READY, then again in the middle of the 0x06 strobe.
        step(); reset = 1'b1; #1;
        step(); reset = 1'b0; #1;
        chk("reset from ready", 32'(bus_now()), 32'h0);
        step(); start = 1'b1; #1;
        step(); start = 1'b0; #1;
        chk("rst seq init_go", 32'(bus_now()), 32'h2000);
        step(); init_done = 1'b1; #1;
        for (int k = 0; k < S + E + NCMD + S + 4; k++) begin
            step(); init_done = 1'b0; #1;
        end
        chk("pulse 0x06", 32'(bus_now()), 32'h0406);
        reset = 1'b1;
        step(); reset = 1'b0; #1;
        chk("reset mid-pulse", 32'(bus_now()), 32'h0);
        for (int k = 0; k < 3; k++) begin step(); #1; end
        chk("stays idle", 32'(bus_now()), 32'h0);
        bring_up("replay");
        do_write("after replay", 1'b1, 8'h5A, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
